// File: rtl/mac_multi_acc_if.sv
// mac_multi_acc_if
//   Operand/result bundle between the EXU issue logic and the multi-accumulator
//   MAC unit. clk and rst are plain ports on the MAC and are not carried here.
//   master : issue side; drives freeze, flush, in_* and observes in_ready, out_*, busy
//   slave  : the MAC unit itself
//   Signals:
//     freeze, flush          global stall / pipeline kill
//     in_valid, in_ready     op handshake (in_ready = ~freeze)
//     in_op                  00 MUL, 01 MAC, 10 MSU, 11 CLR
//     in_signed              operand interpretation
//     in_acc_idx             accumulator selector
//     in_a, in_b             operands
//     in_rd_addr, in_tag     writeback routing carried through the pipe
//     out_valid              one-cycle result strobe
//     out_data, out_rd_addr, out_tag, out_sat   retiring op
//     busy                   any stage occupied
interface mac_multi_acc_if #(
    parameter int OPW  = 16,
    parameter int ACCW = 40,
    parameter int NACC = 4,
    parameter int TAGW = 32
);
    localparam int IDXW = (NACC > 1) ? $clog2(NACC) : 1;

    logic            freeze;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic            in_signed;
    logic [IDXW-1:0] in_acc_idx;
    logic [OPW-1:0]  in_a;
    logic [OPW-1:0]  in_b;
    logic [4:0]      in_rd_addr;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic [4:0]      out_rd_addr;
    logic [TAGW-1:0] out_tag;
    logic            out_sat;
    logic            busy;

    modport master (
        output freeze, flush, in_valid, in_op, in_signed, in_acc_idx, in_a, in_b, in_rd_addr, in_tag,
        input  in_ready, out_valid, out_data, out_rd_addr, out_tag, out_sat, busy
    );

    modport slave (
        input  freeze, flush, in_valid, in_op, in_signed, in_acc_idx, in_a, in_b, in_rd_addr, in_tag,
        output in_ready, out_valid, out_data, out_rd_addr, out_tag, out_sat, busy
    );
endinterface

// File: rtl/mac_multi_acc.sv
// mac_multi_acc
//   Four-stage pipelined multiply-accumulate unit with NACC accumulators.
//   S1 captures the op, S2 forms radix-4 Booth partial products, S3 sums them
//   into a 2*OPW product, S4 extends/accumulates and commits the accumulator.
//   Optional feature macro: MAC_SAT_EN (saturating MAC/MSU; otherwise wrap).
//   Ports:
//     clk  clock
//     rst  asynchronous reset, active-high
//     bus  mac_multi_acc_if.slave (freeze/flush, in_* op, out_* result, busy)
module mac_multi_acc #(
    parameter int OPW  = 16,
    parameter int ACCW = 40,
    parameter int NACC = 4,
    parameter int TAGW = 32
) (
    input logic            clk,
    input logic            rst,
    mac_multi_acc_if.slave bus
);
    localparam int IDXW = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int PW   = 2 * OPW;
    // Operands are extended by two bits so unsigned inputs fit the signed Booth
    // recoding; this adds one partial product over the signed case.
    localparam int NPP  = OPW / 2 + 1;
`ifdef MAC_SAT_EN
    localparam int SW   = ACCW + 1;   // one extra bit exposes overflow/borrow
`else
    localparam int SW   = ACCW;
`endif

    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MAC = 2'b01, OP_MSU = 2'b10, OP_CLR = 2'b11} op_e;

    typedef struct packed {
        op_e             op;
        logic            sgn;
        logic [IDXW-1:0] idx;
        logic [4:0]      rd;
        logic [TAGW-1:0] tag;
    } meta_t;

    logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic            s3_valid_q, s3_valid_d, s4_valid_q, s4_valid_d;
    meta_t           s1_meta_q, s1_meta_d, s2_meta_q, s2_meta_d, s3_meta_q, s3_meta_d;
    logic [OPW-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [PW-1:0]   s2_pp_q [NPP];
    logic [PW-1:0]   s2_pp_d [NPP];
    logic [PW-1:0]   s3_prod_q, s3_prod_d;
    logic [ACCW-1:0] s4_data_q, s4_data_d;
    logic [4:0]      s4_rd_q, s4_rd_d;
    logic [TAGW-1:0] s4_tag_q, s4_tag_d;
    logic [ACCW-1:0] acc_q [NACC];
    logic [ACCW-1:0] acc_d [NACC];
`ifdef MAC_SAT_EN
    logic            s4_sat_q, s4_sat_d;
`endif

    logic [PW-1:0]    a_ext, mag;
    logic [OPW+2:0]   b_pad;
    logic [2:0]       trip;
    logic [IDXW-1:0]  idx_eff;
    logic [ACCW-1:0]  acc_cur, prod_ext, res;
    logic [SW-1:0]    acc_w, prod_w, sum_w;

    always_comb begin
        // S1: capture
        s1_valid_d = bus.in_valid & ~bus.flush;
        s1_meta_d  = '{op: op_e'(bus.in_op), sgn: bus.in_signed, idx: bus.in_acc_idx,
                       rd: bus.in_rd_addr, tag: bus.in_tag};
        s1_a_d     = bus.in_a;
        s1_b_d     = bus.in_b;

        // S2: radix-4 Booth partial products, each pre-shifted and kept mod 2^PW
        if (s1_meta_q.sgn) begin
            a_ext = PW'($signed(s1_a_q));
            b_pad = {{2{s1_b_q[OPW-1]}}, s1_b_q, 1'b0};
        end else begin
            a_ext = PW'(s1_a_q);
            b_pad = {2'b00, s1_b_q, 1'b0};
        end
        trip = 3'b000;
        mag  = '0;
        for (int i = 0; i < NPP; i++) begin
            trip = b_pad[2*i +: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = a_ext;
                3'b011, 3'b100:                 mag = a_ext << 1;
                default:                        mag = '0;
            endcase
            s2_pp_d[i] = (trip[2] ? (PW'(0) - mag) : mag) << (2 * i);
        end
        s2_valid_d = s1_valid_q & ~bus.flush;
        s2_meta_d  = s1_meta_q;

        // S3: reduce
        s3_prod_d = '0;
        for (int i = 0; i < NPP; i++) begin
            s3_prod_d = s3_prod_d + s2_pp_q[i];
        end
        s3_valid_d = s2_valid_q & ~bus.flush;
        s3_meta_d  = s2_meta_q;

        // S4: reads the committed accumulator, so a dependent op one cycle
        // behind already sees the previous result without forwarding.
        idx_eff = (NACC > 1) ? s3_meta_q.idx : '0;
        acc_cur = acc_q[idx_eff];
        if (s3_meta_q.sgn) begin
            prod_ext = ACCW'($signed(s3_prod_q));
            acc_w    = SW'($signed(acc_cur));
            prod_w   = SW'($signed(prod_ext));
        end else begin
            prod_ext = ACCW'(s3_prod_q);
            acc_w    = SW'(acc_cur);
            prod_w   = SW'(prod_ext);
        end
        sum_w = (s3_meta_q.op == OP_MSU) ? (acc_w - prod_w) : (acc_w + prod_w);
        case (s3_meta_q.op)
            OP_MUL:  res = prod_ext;
            OP_CLR:  res = '0;
            default: res = sum_w[ACCW-1:0];
        endcase
`ifdef MAC_SAT_EN
        s4_sat_d = s4_sat_q;
        if (s3_valid_q && !bus.flush) begin
            s4_sat_d = 1'b0;
        end
        if (s3_meta_q.op == OP_MAC || s3_meta_q.op == OP_MSU) begin
            if (s3_meta_q.sgn) begin
                if (sum_w[ACCW] != sum_w[ACCW-1]) begin
                    res = sum_w[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
                    if (s3_valid_q && !bus.flush) s4_sat_d = 1'b1;
                end
            end else if (sum_w[ACCW]) begin
                // carry on MAC clamps high, borrow on MSU clamps to zero
                res = (s3_meta_q.op == OP_MAC) ? '1 : '0;
                if (s3_valid_q && !bus.flush) s4_sat_d = 1'b1;
            end
        end
`endif
        s4_valid_d = s3_valid_q & ~bus.flush;
        s4_data_d  = s4_data_q;
        s4_rd_d    = s4_rd_q;
        s4_tag_d   = s4_tag_q;
        acc_d      = acc_q;
        if (s4_valid_d) begin
            s4_data_d = res;
            s4_rd_d   = s3_meta_q.rd;
            s4_tag_d  = s3_meta_q.tag;
            if (s3_meta_q.op != OP_MUL) begin
                acc_d[idx_eff] = res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
            s1_meta_q  <= '0;
            s2_meta_q  <= '0;
            s3_meta_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_pp_q    <= '{default: '0};
            s3_prod_q  <= '0;
            s4_data_q  <= '0;
            s4_rd_q    <= '0;
            s4_tag_q   <= '0;
            acc_q      <= '{default: '0};
`ifdef MAC_SAT_EN
            s4_sat_q   <= 1'b0;
`endif
        end else if (!bus.freeze) begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s4_valid_q <= s4_valid_d;
            s1_meta_q  <= s1_meta_d;
            s2_meta_q  <= s2_meta_d;
            s3_meta_q  <= s3_meta_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_pp_q    <= s2_pp_d;
            s3_prod_q  <= s3_prod_d;
            s4_data_q  <= s4_data_d;
            s4_rd_q    <= s4_rd_d;
            s4_tag_q   <= s4_tag_d;
            acc_q      <= acc_d;
`ifdef MAC_SAT_EN
            s4_sat_q   <= s4_sat_d;
`endif
        end
    end

    assign bus.in_ready    = ~bus.freeze;
    // Gating with freeze keeps a held S4 op from strobing more than once.
    assign bus.out_valid   = s4_valid_q & ~bus.freeze;
    assign bus.out_data    = s4_data_q;
    assign bus.out_rd_addr = s4_rd_q;
    assign bus.out_tag     = s4_tag_q;
    assign bus.busy        = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;
`ifdef MAC_SAT_EN
    assign bus.out_sat     = s4_sat_q;
`else
    assign bus.out_sat     = 1'b0;
`endif
endmodule

// File: tb/tb_mac_multi_acc.sv
module tb_mac_multi_acc;
    localparam int OPW  = 16;
    localparam int ACCW = 40;
    localparam int NACC = 4;
    localparam int TAGW = 32;

    typedef struct {
        logic [ACCW-1:0] data;
        logic            sat;
        logic [4:0]      rd;
        logic [TAGW-1:0] tag;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mac_multi_acc_if #(.OPW(OPW), .ACCW(ACCW), .NACC(NACC), .TAGW(TAGW)) bus ();

    mac_multi_acc #(.OPW(OPW), .ACCW(ACCW), .NACC(NACC), .TAGW(TAGW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nstrobe = 0;
    int   npush = 0;
    int   ntag = 0;
    bit   chk_lat = 1'b1;
    exp_t sbq[$];
    logic [ACCW-1:0] acc_m [NACC];

    always @(posedge clk) cyc <= cyc + 1;

    // independent reference: plain 64-bit integer arithmetic
    function automatic logic [ACCW:0] model(input logic [1:0] op, input logic sgn,
                                            input logic [ACCW-1:0] acc,
                                            input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        longint p, av, r;
        logic   s;
        if (sgn) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            av = longint'($signed(acc));
        end else begin
            p  = longint'(a) * longint'(b);
            av = longint'(acc);
        end
        case (op)
            2'b00:   r = p;
            2'b01:   r = av + p;
            2'b10:   r = av - p;
            default: r = 0;
        endcase
        s = 1'b0;
`ifdef MAC_SAT_EN
        if (op == 2'b01 || op == 2'b10) begin
            if (sgn) begin
                if (r > (64'sd1 <<< (ACCW-1)) - 1) begin r = (64'sd1 <<< (ACCW-1)) - 1; s = 1'b1; end
                if (r < -(64'sd1 <<< (ACCW-1)))    begin r = -(64'sd1 <<< (ACCW-1));    s = 1'b1; end
            end else begin
                if (r > (64'sd1 <<< ACCW) - 1) begin r = (64'sd1 <<< ACCW) - 1; s = 1'b1; end
                if (r < 0)                     begin r = 0;                     s = 1'b1; end
            end
        end
`endif
        return {s, r[ACCW-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic sgn, input int idx,
                         input logic [OPW-1:0] a, input logic [OPW-1:0] b, input bit push);
        logic [ACCW:0] m;
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_signed  = sgn;
        bus.in_acc_idx = 2'(idx);
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_rd_addr = 5'(ntag);
        bus.in_tag     = 32'hA000_0000 + 32'(ntag);
        @(posedge clk);
        #1;
        if (push) begin
            m = model(op, sgn, acc_m[idx], a, b);
            if (op != 2'b00) acc_m[idx] = m[ACCW-1:0];
            e.data = m[ACCW-1:0];
            e.sat  = m[ACCW];
            e.rd   = 5'(ntag);
            e.tag  = 32'hA000_0000 + 32'(ntag);
            e.cyc  = chk_lat ? cyc + 3 : -1;
            sbq.push_back(e);
            npush++;
        end
        ntag++;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string name);
        @(negedge clk);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_busy"},      64'(bus.busy),      64'd0);
        check({name, "_out_data"},  64'(bus.out_data),  64'd0);
        check({name, "_out_tag"},   64'(bus.out_tag),   64'd0);
        check({name, "_out_rd"},    64'(bus.out_rd_addr), 64'd0);
        check({name, "_out_sat"},   64'(bus.out_sat),   64'd0);
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid === 1'b1) begin
            nstrobe++;
            total++;
            assert (sbq.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_strobe observed data=%h tag=%h expected no strobe", bus.out_data, bus.out_tag);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                assert (bus.out_data === e.data) else begin
                    bad++; $error("FAIL out_data tag=%h observed=%h expected=%h", e.tag, bus.out_data, e.data);
                end
                total++;
                assert ({bus.out_rd_addr, bus.out_tag} === {e.rd, e.tag}) else begin
                    bad++; $error("FAIL rd_tag observed=%h/%h expected=%h/%h", bus.out_rd_addr, bus.out_tag, e.rd, e.tag);
                end
                total++;
                assert (bus.out_sat === e.sat) else begin
                    bad++; $error("FAIL out_sat tag=%h observed=%b expected=%b", e.tag, bus.out_sat, e.sat);
                end
                if (e.cyc >= 0) begin
                    total++;
                    assert (cyc === e.cyc) else begin
                        bad++; $error("FAIL latency tag=%h observed_cycle=%0d expected_cycle=%0d", e.tag, cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        bus.freeze = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = 2'b00;
        bus.in_signed = 1'b0; bus.in_acc_idx = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_rd_addr = '0; bus.in_tag = '0;
        for (int i = 0; i < NACC; i++) acc_m[i] = '0;

        // reset state
        reset_checks("reset");
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // MUL signed/unsigned, then accumulator 0 must still be zero
        issue(2'b00, 1'b1, 0, 16'hFFFD, 16'h0007, 1'b1);
        issue(2'b00, 1'b0, 0, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(2'b01, 1'b1, 0, 16'h0000, 16'h0000, 1'b1);
        idle(6);

        // CLR then back-to-back dependent MACs
        issue(2'b11, 1'b1, 2, 16'h1234, 16'h5678, 1'b1);
        for (int i = 0; i < 3; i++) issue(2'b01, 1'b1, 2, 16'd100, 16'd200, 1'b1);
        idle(6);
        @(negedge clk);
        check("hold_out_data", 64'(bus.out_data), 64'd60000);
        check("hold_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // reset with an op in flight drops it
        issue(2'b01, 1'b1, 0, 16'd9, 16'd9, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NACC; i++) acc_m[i] = '0;
        reset_checks("midreset");
        @(posedge clk); #1;
        rst = 1'b0;

        // interleaved accumulators
        issue(2'b01, 1'b1, 0, 16'd5, 16'd5, 1'b1);
        issue(2'b10, 1'b1, 1, 16'd3, 16'd4, 1'b1);
        issue(2'b01, 1'b1, 0, 16'd2, 16'd2, 1'b1);
        idle(6);
        @(negedge clk);
        check("interleave_last", 64'(bus.out_data), 64'd29);
        @(posedge clk); #1;

        // freeze mid-flight, including while an op sits in S4
        chk_lat = 1'b0;
        issue(2'b01, 1'b1, 1, 16'd1, 16'd1, 1'b1);
        issue(2'b01, 1'b1, 1, 16'd2, 16'd2, 1'b1);
        issue(2'b01, 1'b1, 1, 16'd3, 16'd3, 1'b1);
        idle(1);
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frozen_out_valid", 64'(bus.out_valid), 64'd0);
            check("frozen_in_ready", 64'(bus.in_ready), 64'd0);
            check("frozen_busy", 64'(bus.busy), 64'd1);
            @(posedge clk); #1;
        end
        bus.freeze = 1'b0;
        idle(6);
        check("freeze_strobe_count", 64'(nstrobe), 64'(npush));

        // flush kills young ops and the op presented during flush
        chk_lat = 1'b1;
        issue(2'b01, 1'b1, 3, 16'd7, 16'd7, 1'b0);
        issue(2'b01, 1'b1, 3, 16'd8, 16'd8, 1'b0);
        bus.flush = 1'b1;
        bus.in_a = 16'd9; bus.in_b = 16'd9;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        issue(2'b01, 1'b1, 3, 16'd0, 16'd0, 1'b1);
        idle(6);

        // flush together with freeze: freeze wins
        chk_lat = 1'b0;
        issue(2'b01, 1'b1, 3, 16'd2, 16'd3, 1'b1);
        issue(2'b01, 1'b1, 3, 16'd1, 16'd1, 1'b1);
        bus.in_valid = 1'b0;
        bus.freeze = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.freeze = 1'b0;
        bus.flush = 1'b0;
        idle(6);
        @(negedge clk);
        check("flush_freeze_last", 64'(bus.out_data), 64'd7);
        @(posedge clk); #1;

        // overflow boundary: build 2^39-1 in acc0 then add 1
        chk_lat = 1'b1;
        issue(2'b11, 1'b1, 0, 16'd0, 16'd0, 1'b1);
        issue(2'b10, 1'b1, 0, 16'd1, 16'd1, 1'b1);
        for (int i = 0; i < 512; i++) issue(2'b01, 1'b1, 0, 16'h8000, 16'h8000, 1'b1);
        issue(2'b01, 1'b1, 0, 16'd1, 16'd1, 1'b1);
        idle(6);
        @(negedge clk);
`ifdef MAC_SAT_EN
        check("sat_signed_data", 64'(bus.out_data), 64'h7F_FFFF_FFFF);
        check("sat_signed_flag", 64'(bus.out_sat), 64'd1);
`else
        check("wrap_signed_data", 64'(bus.out_data), 64'h80_0000_0000);
        check("wrap_signed_flag", 64'(bus.out_sat), 64'd0);
`endif
        @(posedge clk); #1;
        issue(2'b11, 1'b0, 1, 16'd0, 16'd0, 1'b1);
        issue(2'b10, 1'b0, 1, 16'd1, 16'd1, 1'b1);
        idle(6);
        @(negedge clk);
`ifdef MAC_SAT_EN
        check("sat_unsigned_data", 64'(bus.out_data), 64'h0);
`else
        check("wrap_unsigned_data", 64'(bus.out_data), 64'hFF_FFFF_FFFF);
`endif
        @(posedge clk); #1;

        idle(4);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        check("strobe_count", 64'(nstrobe), 64'(npush));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
